seq_left_shifter: RTL and testbench

//   Multi-cycle left-shift / rotate-left unit for the 8-bit processor datapath.

---
 rtl/seq_left_shifter_if.sv | 25 ++
 rtl/seq_left_shifter.sv | 94 +++++++++
 tb/tb_seq_left_shifter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seq_left_shifter_if.sv
// Operand/result bundle between the datapath controller and the sequential left shifter.
// The master issues start plus operands; the slave returns the result and busy/done status.
interface seq_left_shifter_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [AMT_W-1:0] amount;
  logic             mode;
  logic             fill;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  modport master (
    output start, data_in, amount, mode, fill,
    input  data_out, busy, done
  );

  modport slave (
    input  start, data_in, amount, mode, fill,
    output data_out, busy, done
  );
endinterface

// File: rtl/seq_left_shifter.sv
// Multi-cycle LSL/ROL unit, one bit per clock; done pulses the cycle after the last shift (N+1 cycles).
// No backpressure: start is only sampled in IDLE; busy/done are decoded from state.
module seq_left_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input logic               clk,
  input logic               rst,
  seq_left_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  typedef struct packed {
    logic mode;
    logic fill;
  } op_t;

  state_e           state, state_n;
  op_t              op, op_n;
  logic [WIDTH-1:0] work, work_n;
  logic [WIDTH-1:0] dout, dout_n;
  logic [WIDTH-1:0] shifted;
  logic [AMT_W-1:0] count, count_n;

  // Rotate feeds the MSB back in; logical shift feeds the latched fill bit.
  always_comb begin
    shifted = {work[WIDTH-2:0], (op.mode ? work[WIDTH-1] : op.fill)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= '0;
      work  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      state <= state_n;
      op    <= op_n;
      work  <= work_n;
      count <= count_n;
      dout  <= dout_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op;
    work_n  = work;
    count_n = count;
    dout_n  = dout;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          op_n.mode = bus.mode;
          op_n.fill = bus.fill;
          if (bus.amount == '0) begin
            dout_n  = bus.data_in;
            state_n = FINISH;
          end else begin
            work_n  = bus.data_in;
            count_n = bus.amount;
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_n  = shifted;
        count_n = count - AMT_W'(1);
        // count stops at 1, so it never wraps and no early exit is taken for large amounts
        if (count == AMT_W'(1)) begin
          dout_n  = shifted;
          state_n = FINISH;
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.data_out = dout;
  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == FINISH);

endmodule

// File: tb/tb_seq_left_shifter.sv
// Directed bench for seq_left_shifter: reset, LSL/ROL, zero/large amounts, handshake corners.
module tb_seq_left_shifter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_left_shifter_if #(.WIDTH(8), .AMT_W(4)) bus ();

  seq_left_shifter #(.WIDTH(8), .AMT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_cmp    = 0;
  int         n_bad    = 0;
  logic [7:0] last_res = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, scramble inputs afterwards, and check timing and result.
  task automatic do_op(input string tag, input logic [7:0] din, input logic [3:0] amt,
                       input logic m, input logic f, input logic [7:0] exp, input bit poke);
    int   guard;
    int   busy_n;
    logic hold_bad;
    logic overlap;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = din;
    bus.amount  = amt;
    bus.mode    = m;
    bus.fill    = f;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = 8'hFF;
    bus.amount  = 4'hF;
    bus.mode    = ~m;
    bus.fill    = ~f;
    guard    = 0;
    busy_n   = 0;
    hold_bad = 1'b0;
    overlap  = 1'b0;
    while (bus.done !== 1'b1 && guard < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.data_out !== last_res) hold_bad = 1'b1;
      if (poke && guard == 1) begin
        bus.start   = 1'b1;
        bus.data_in = 8'h01;
        bus.amount  = 4'h0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b0;
    if (bus.busy === 1'b1) overlap = 1'b1;
    chk({tag, " done"}, bus.done, 1);
    chk({tag, " latency"}, guard, amt);
    chk({tag, " busy cycles"}, busy_n, amt);
    chk({tag, " busy&done"}, overlap, 0);
    chk({tag, " hold"}, hold_bad, 0);
    chk({tag, " result"}, bus.data_out, exp);
    last_res = exp;
    @(negedge clk);
    chk({tag, " done pulse"}, bus.done, 0);
    chk({tag, " idle busy"}, bus.busy, 0);
    chk({tag, " result held"}, bus.data_out, exp);
  endtask

  initial begin
    logic done_seen;
    logic busy_seen;
    bus.start   = 1'b0;
    bus.data_in = 8'h00;
    bus.amount  = 4'h0;
    bus.mode    = 1'b0;
    bus.fill    = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset dout", bus.data_out, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op("lsl 96<<3", 8'h96, 4'd3, 1'b0, 1'b0, 8'hB0, 1'b0);
    do_op("rol 96 r3", 8'h96, 4'd3, 1'b1, 1'b0, 8'hB4, 1'b0);
    do_op("rol 96 r12", 8'h96, 4'd12, 1'b1, 1'b0, 8'h69, 1'b0);
    do_op("zero 5A", 8'h5A, 4'd0, 1'b0, 1'b0, 8'h5A, 1'b0);
    do_op("fill1 n9", 8'h00, 4'd9, 1'b0, 1'b1, 8'hFF, 1'b0);
    do_op("fill0 n15", 8'hA5, 4'd15, 1'b0, 1'b0, 8'h00, 1'b0);
    do_op("start ignored", 8'h96, 4'd3, 1'b1, 1'b0, 8'hB4, 1'b1);

    // Reset in the middle of a 9-cycle rotate: outputs clear without a clock edge.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 8'h96;
    bus.amount  = 4'd9;
    bus.mode    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rst pre busy", bus.busy, 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst mid busy", bus.busy, 0);
    chk("rst mid done", bus.done, 0);
    chk("rst mid dout", bus.data_out, 8'h00);
    #1 rst = 1'b0;
    last_res  = 8'h00;
    done_seen = 1'b0;
    busy_seen = 1'b0;
    repeat (14) begin
      @(negedge clk);
      done_seen = done_seen | bus.done;
      busy_seen = busy_seen | bus.busy;
    end
    chk("rst no done", done_seen, 0);
    chk("rst no busy", busy_seen, 0);

    // Back-to-back with start held: 0x81 ROL 1 then 0x03 LSL 2.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 8'h81;
    bus.amount  = 4'd1;
    bus.mode    = 1'b1;
    bus.fill    = 1'b0;
    @(negedge clk);
    chk("b2b op1 busy", bus.busy, 1);
    bus.data_in = 8'h03;
    bus.amount  = 4'd2;
    bus.mode    = 1'b0;
    @(negedge clk);
    chk("b2b op1 done", bus.done, 1);
    chk("b2b op1 dout", bus.data_out, 8'h03);
    @(negedge clk);
    chk("b2b gap busy", bus.busy, 0);
    chk("b2b gap done", bus.done, 0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b op2 busy1", bus.busy, 1);
    chk("b2b op2 hold", bus.data_out, 8'h03);
    @(negedge clk);
    chk("b2b op2 busy2", bus.busy, 1);
    @(negedge clk);
    chk("b2b op2 done", bus.done, 1);
    chk("b2b op2 dout", bus.data_out, 8'h0C);
    @(negedge clk);
    chk("b2b end done", bus.done, 0);
    chk("b2b end busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
